// File: rtl/mem_burst_arbiter.sv
// Shares one system-memory burst port between the I-fetch refill and D-side refill/writeback paths.
// Define ARB_RR_EN to alternate grants on simultaneous requests; otherwise the D side wins ties.
module mem_burst_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic                  i_rlast,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic                  d_rlast,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_wvalid,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_wready,
  output logic                  d_wdone,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  input  logic                  m_ack,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_wvalid,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  input  logic                  m_wready,
  output logic                  proto_err
);

  // state  | meaning
  // IDLE   | no burst in flight, arbitrating requests
  // CMD    | command presented on m_req, waiting for m_ack
  // RBURST | forwarding read beats to the owner
  // WBURST | passing D-side write beats to memory
  typedef enum logic [1:0] {IDLE, CMD, RBURST, WBURST} state_e;

  localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_BURST_LEN - 1);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = D side owns the burst
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  i_gnt_q, i_gnt_d;
  logic                  d_gnt_q, d_gnt_d;
  logic                  wdone_q, wdone_d;
  logic                  perr_q, perr_d;
  logic                  d_win;
`ifdef ARB_RR_EN
  logic                  last_d_q, last_d_d;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    i_gnt_d = 1'b0;
    d_gnt_d = 1'b0;
    wdone_d = 1'b0;
    perr_d  = perr_q | (m_rvalid && state_q != RBURST) | (m_ack && state_q != CMD);
`ifdef ARB_RR_EN
    last_d_d = last_d_q;
    d_win    = d_req & (~i_req | ~last_d_q);
`else
    d_win    = d_req;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = CMD;
          owner_d = d_win;
          addr_d  = d_win ? d_addr : i_addr;
          we_d    = d_win & d_we;
`ifdef ARB_RR_EN
          last_d_d = d_win;
`endif
        end
      end
      CMD: begin
        if (m_ack) begin
          cnt_d   = '0;
          state_d = we_q ? WBURST : RBURST;
          i_gnt_d = ~owner_q;
          d_gnt_d = owner_q;
        end
      end
      RBURST: begin
        if (m_rvalid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == R_LAST) state_d = IDLE;
        end
      end
      WBURST: begin
        if (d_wvalid && m_wready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == W_LAST) begin
            state_d = IDLE;
            wdone_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      i_gnt_q  <= 1'b0;
      d_gnt_q  <= 1'b0;
      wdone_q  <= 1'b0;
      perr_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      i_gnt_q  <= i_gnt_d;
      d_gnt_q  <= d_gnt_d;
      wdone_q  <= wdone_d;
      perr_q   <= perr_d;
`ifdef ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  logic rd_i, rd_d, wr;
  assign rd_i = (state_q == RBURST) && !owner_q;
  assign rd_d = (state_q == RBURST) && owner_q;
  assign wr   = (state_q == WBURST);

  assign m_req     = (state_q == CMD);
  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign d_wdone   = wdone_q;
  assign proto_err = perr_q;

  // Read data is forwarded in the same cycle it arrives from memory.
  assign i_rvalid = rd_i & m_rvalid;
  assign i_rlast  = i_rvalid & (cnt_q == R_LAST);
  assign i_rdata  = rd_i ? m_rdata : '0;
  assign d_rvalid = rd_d & m_rvalid;
  assign d_rlast  = d_rvalid & (cnt_q == R_LAST);
  assign d_rdata  = rd_d ? m_rdata : '0;

  assign m_wvalid = wr & d_wvalid;
  assign m_wdata  = wr ? d_wdata : '0;
  assign d_wready = wr & m_wready;
  assign m_wlast  = wr & (cnt_q == W_LAST);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: table-driven read beats plus hand sequences for
// write stalls, tie arbitration, delayed ack, protocol errors and mid-burst reset.
module tb_mem_burst_arbiter;

  logic        sys_clk, sys_rst_n;
  logic        i_req, i_gnt, i_rvalid, i_rlast;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_rlast, d_wvalid, d_wready, d_wdone;
  logic [31:0] d_addr, d_rdata, d_wdata;
  logic        m_req, m_we, m_ack, m_rvalid, m_wvalid, m_wlast, m_wready, proto_err;
  logic [31:0] m_addr, m_rdata, m_wdata;

  int n_vec = 0;
  int n_err = 0;
  int wb, cyc;
  logic exp_d;
  logic exp_wready;

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        e_rv;
    logic        e_last;
    logic        e_gnt;
  } beat_t;
  beat_t tbl[10];

  mem_burst_arbiter dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rlast(i_rlast), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
    .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wready(d_wready), .d_wdone(d_wdone),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ack(m_ack),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wready(m_wready),
    .proto_err(proto_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_i_gnt"}, i_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_i_rvalid"}, i_rvalid, 0);
    chk({tag, "_i_rlast"}, i_rlast, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_d_rlast"}, d_rlast, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_d_wready"}, d_wready, 0);
    chk({tag, "_d_wdone"}, d_wdone, 0);
    chk({tag, "_m_wvalid"}, m_wvalid, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wlast"}, m_wlast, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  // Eight back-to-back read beats to one owner, starting in the current cycle.
  task automatic read_beats(input logic to_d, input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + 32'(k);
      #1;
      chk("rb_own_rvalid", to_d ? d_rvalid : i_rvalid, 1);
      chk("rb_own_rdata", to_d ? d_rdata : i_rdata, base + 32'(k));
      chk("rb_own_rlast", to_d ? d_rlast : i_rlast, (k == 7) ? 1 : 0);
      chk("rb_other_rvalid", to_d ? i_rvalid : d_rvalid, 0);
      step();
    end
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h5, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h6, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 32'h7, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 32'h8, 1'b1, 1'b1, 1'b0};

    sys_rst_n = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wvalid = 0; d_wdata = '0; m_ack = 0; m_rvalid = 0; m_rdata = '0; m_wready = 0;
    step(); step();
    #1;
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    step();

    // single I read with gaps in m_rvalid
    i_req = 1; i_addr = 32'h40;
    #1 chk("ird_idle_mreq", m_req, 0);
    step();
    #1;
    chk("ird_cmd_mreq", m_req, 1);
    chk("ird_cmd_addr", m_addr, 32'h40);
    chk("ird_cmd_we", m_we, 0);
    chk("ird_cmd_gnt", i_gnt, 0);
    m_ack = 1;
    step();
    m_ack = 0; i_req = 0;
    for (int r = 0; r < 10; r++) begin
      m_rvalid = tbl[r].rv;
      m_rdata  = tbl[r].rd;
      #1;
      chk("ird_i_rvalid", i_rvalid, tbl[r].e_rv);
      chk("ird_i_rlast", i_rlast, tbl[r].e_last);
      chk("ird_i_gnt", i_gnt, tbl[r].e_gnt);
      chk("ird_d_rvalid", d_rvalid, 0);
      chk("ird_d_gnt", d_gnt, 0);
      chk("ird_m_req", m_req, 0);
      if (tbl[r].rv) chk("ird_i_rdata", i_rdata, tbl[r].rd);
      step();
    end
    m_rvalid = 0; m_rdata = '0;
    #1;
    chk("ird_done_mreq", m_req, 0);
    chk("ird_done_perr", proto_err, 0);

    // D write, m_wready low on alternate cycles
    d_req = 1; d_we = 1; d_addr = 32'h100;
    step();
    #1;
    chk("dwr_cmd_mreq", m_req, 1);
    chk("dwr_cmd_addr", m_addr, 32'h100);
    chk("dwr_cmd_we", m_we, 1);
    m_ack = 1;
    step();
    m_ack = 0; d_req = 0; d_wvalid = 1;
    #1 chk("dwr_d_gnt", d_gnt, 1);
    wb = 0; cyc = 0;
    while (wb < 8 && cyc < 40) begin
      exp_wready = (cyc % 2 == 1);
      m_wready = exp_wready;
      d_wdata  = 32'hA0 + 32'(wb);
      #1;
      chk("dwr_m_wvalid", m_wvalid, 1);
      chk("dwr_m_wdata", m_wdata, 32'hA0 + 32'(wb));
      chk("dwr_m_wlast", m_wlast, (wb == 7) ? 1 : 0);
      chk("dwr_d_wready", d_wready, exp_wready);
      chk("dwr_d_wdone_early", d_wdone, 0);
      if (exp_wready) wb++;
      cyc++;
      step();
    end
    chk("dwr_beats", wb, 8);
    d_wvalid = 0; m_wready = 0;
    #1;
    chk("dwr_wdone", d_wdone, 1);
    chk("dwr_after_wvalid", m_wvalid, 0);
    step();
    #1 chk("dwr_wdone_pulse", d_wdone, 0);

    // three simultaneous requests, starting from reset pointer state
    sys_rst_n = 0; step(); sys_rst_n = 1; step();
    for (int rnd = 0; rnd < 3; rnd++) begin
`ifdef ARB_RR_EN
      exp_d = (rnd != 1);
`else
      exp_d = 1'b1;
`endif
      i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300; d_we = 0;
      step();
      #1;
      chk("tie_mreq", m_req, 1);
      chk("tie_addr", m_addr, exp_d ? 32'h300 : 32'h200);
      m_ack = 1;
      step();
      m_ack = 0;
      if (exp_d) d_req = 0; else i_req = 0;
      #1;
      chk("tie_d_gnt", d_gnt, exp_d);
      chk("tie_i_gnt", i_gnt, !exp_d);
      read_beats(exp_d, 32'h10 * 32'(rnd));
    end
    i_req = 0; d_req = 0;
    step();

    // delayed ack
    d_req = 1; d_we = 0; d_addr = 32'h480;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("dack_mreq", m_req, 1);
      chk("dack_addr", m_addr, 32'h480);
      chk("dack_gnt", d_gnt, 0);
      step();
    end
    m_ack = 1;
    step();
    m_ack = 0; d_req = 0;
    #1 chk("dack_d_gnt", d_gnt, 1);
    read_beats(1'b1, 32'h70);
    #1 chk("dack_idle_mreq", m_req, 0);

    // spurious m_rvalid in IDLE
    m_rvalid = 1; m_rdata = 32'h55;
    #1;
    chk("spur_i_rvalid", i_rvalid, 0);
    chk("spur_d_rvalid", d_rvalid, 0);
    step();
    m_rvalid = 0; m_rdata = '0;
    #1 chk("spur_perr", proto_err, 1);
    step(); step();
    #1;
    chk("spur_perr_sticky", proto_err, 1);
    chk("spur_mreq", m_req, 0);

    // reset after third beat of an I read
    i_req = 1; i_addr = 32'h800;
    step();
    m_ack = 1;
    step();
    m_ack = 0; i_req = 0;
    for (int k = 0; k < 3; k++) begin
      m_rvalid = 1; m_rdata = 32'(k + 1);
      #1 chk("rmid_i_rvalid", i_rvalid, 1);
      step();
    end
    m_rvalid = 0; m_rdata = '0;
    sys_rst_n = 0;
    step();
    #1 chk_all_zero("rmid");
    sys_rst_n = 1;
    step();
    #1 chk("rmid_idle_mreq", m_req, 0);

    // D read after the abandoned burst
    d_req = 1; d_we = 0; d_addr = 32'h600;
    step();
    #1;
    chk("drd_addr", m_addr, 32'h600);
    chk("drd_we", m_we, 0);
    m_ack = 1;
    step();
    m_ack = 0; d_req = 0;
    #1 chk("drd_d_gnt", d_gnt, 1);
    read_beats(1'b1, 32'h90);
    #1 chk("drd_perr", proto_err, 0);

    // spurious m_ack in IDLE
    m_ack = 1;
    step();
    m_ack = 0;
    #1;
    chk("sack_perr", proto_err, 1);
    chk("sack_mreq", m_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
